node_port: RTL and testbench
============================

# node_port

Per-node network adapter between the testbench packet interface and a router port. Queues whole `pkt_t` packets from the testbench, serialises them into four 8-bit flits on the outbound put/free link, and reassembles four inbound flits into a `pkt_t` delivered back to the testbench. One instance sits between each testbench node slot and its router port (six in the two-router topology).

## Interface
- `NODEID`, default 0: node number; used only in `$display` traces and the source-field check.
- `DEPTH`, default 4: outbound packet queue depth in packets; power of two, ≥2.

Ports:
- `clock` input 1: system clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `pkt_in` input `pkt_t`: packet from the testbench.
- `pkt_in_avail` input 1: one-cycle write strobe for `pkt_in`.
- `cQ_full` output 1: queue holds `DEPTH` packets.
- `pkt_out` output `pkt_t`: reassembled inbound packet.
- `pkt_out_avail` output 1: one-cycle valid strobe for `pkt_out`.
- `free_outbound` input 1: router port can accept a whole packet.
- `put_outbound` output 1: outbound flit valid.
- `payload_outbound` output 8: outbound flit.
- `free_inbound` output 1: this node can accept a whole packet.
- `put_inbound` input 1: inbound flit valid.
- `payload_inbound` input 8: inbound flit.

## Operation
- `pkt_t` is 32 bits: `{src[3:0], dest[3:0], data[23:0]}`. Flit order is MSB first: [31:24], [23:16], [15:8], [7:0].
- Queue write: `pkt_in` is written on the edge where `pkt_in_avail`=1 and the queue is not full.
  - A write while full is dropped, with a `$display` warning. It does not corrupt state.
  - A simultaneous write and pop on a full queue is a drop, because fullness is judged before the pop.
- TX FSM has two states, `TX_IDLE` and `TX_SEND`, plus a 2-bit flit counter.
  - In `TX_IDLE`, when the queue is non-empty and `free_outbound`=1, the head is popped into a 32-bit shift register. The FSM then moves to `TX_SEND` with count 0.
  - In `TX_SEND`, `put_outbound`=1 and `payload_outbound`=shift[31:24]. The register shifts left 8 bits each cycle.
  - After count 3 the FSM returns to `TX_IDLE`. If the queue is non-empty and `free_outbound`=1 in the count-3 cycle, the next head loads directly and `TX_SEND` continues. Back-to-back packets therefore have no gap.
  - `free_outbound` is sampled only at packet start. Mid-packet changes are ignored.
- RX FSM has three states, `RX_IDLE`, `RX_RECV` and `RX_DONE`, plus a 2-bit counter.
  - `free_inbound`=1 only in `RX_IDLE`.
  - Flit 0 (`put_inbound`=1 in `RX_IDLE`) moves the FSM to `RX_RECV`. Bytes are accumulated MSB first.
  - After flit 3 the FSM moves to `RX_DONE`. There `pkt_out` holds the packet and `pkt_out_avail`=1 for one cycle, then the FSM returns to `RX_IDLE`.
  - If `put_inbound`=0 while in `RX_RECV`, the partial packet is discarded, the FSM returns to `RX_IDLE`, no strobe is produced, and a warning is printed.
- When the `src` field of an outbound packet is not `NODEID`, a warning is printed. The packet is still sent.

## Timing
- Reset values: `cQ_full`=0, `put_outbound`=0, `payload_outbound`=0, `free_inbound`=1, `pkt_out_avail`=0, `pkt_out`=0. Queue is empty; both FSMs are in their IDLE states.
- Reset asserted mid-packet aborts both FSMs immediately. Queued packets are lost.
- All outputs are registered.
- `cQ_full` reflects the occupancy after the current edge.
- TX latency, write to first flit: 2 cycles (write edge, then pop edge; the flit appears after the pop edge), given an empty queue and `free_outbound`=1.
- RX latency: `pkt_out_avail` rises on the edge after flit 3 is captured. `free_inbound` is 0 for 5 cycles per packet.

## Configuration
- `NODE_PORT_BYPASS_EN`
  - Defined: a packet written into an empty queue while TX is idle and `free_outbound`=1 loads straight into the shift register on the write edge. The first flit then appears 1 cycle after the write, and the queue is untouched.
  - Undefined: every packet passes through the queue (2-cycle latency).
  - Flit order and all other behaviour are identical in both cases.

## Structure
- `RouterPkg`: `pkt_t`; new constants `FLITS_PER_PKT`=4 and `FLIT_W`=8.
- Sub-module `node_fifo`, parameterised on `DEPTH` and element type.
  - Ports: write, pop, head, `full`, `empty`, `count`.
  - Pointers are `$clog2(DEPTH)` bits wide with a separate occupancy count, so there is no full/empty wrap ambiguity.

## Test plan
- Reset, then write 0x1234_5678 with `free_outbound`=1 → `put_outbound` high for 4 cycles, payload 0x12, 0x34, 0x56, 0x78; first flit 2 cycles after write (1 with BYPASS_EN).
- With `free_outbound`=0, write 5 packets (`DEPTH`=4) → `cQ_full`=1 after the 4th write, 5th dropped with warning. Raising free then yields 4 back-to-back packets (16 contiguous put cycles).
- Drive put with 0xA1, 0xB2, 0xC3, 0xD4 → `pkt_out`=0xA1B2_C3D4, `pkt_out_avail` one cycle after 0xD4; `free_inbound` low 5 cycles.
- Drop put after 2 inbound flits → no `pkt_out_avail`, `free_inbound`=1 the next cycle, then a following full packet is received correctly.
- Assert `reset_n`=0 during flit 2 of a TX and an RX → all outputs return to reset values asynchronously, and no stray flits or strobes follow.
- Simultaneous TX and RX of different packets → both complete independently with the values above.

Source files
------------

// File: rtl/node_port_pkg.sv
// Shared types and constants for the node network adapter: packet layout,
// flit geometry and the TX/RX state encodings.
package node_port_pkg;

  localparam int unsigned FLITS_PER_PKT = 4;
  localparam int unsigned FLIT_W        = 8;
  localparam int unsigned PKT_W         = FLITS_PER_PKT * FLIT_W;
  localparam int unsigned FLIT_CNT_W    = $clog2(FLITS_PER_PKT);

  typedef struct packed {
    logic [3:0]  src;
    logic [3:0]  dest;
    logic [23:0] data;
  } pkt_t;

  typedef enum logic {
    TX_IDLE,
    TX_SEND
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_RECV,
    RX_DONE
  } rx_state_e;

  // Most significant flit of a packet word; flits travel MSB first.
  function automatic logic [FLIT_W-1:0] head_flit(input logic [PKT_W-1:0] word);
    return word[PKT_W-1 -: FLIT_W];
  endfunction

endpackage

// File: rtl/node_port_fifo.sv
// Outbound packet queue: DEPTH-entry circular buffer with a separate
// occupancy count so full and empty are never ambiguous.
module node_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = logic [31:0]
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_i,
  input  T                         wr_data_i,
  input  logic                     pop_i,
  output T                         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q;
  logic             wr_ok_c, pop_ok_c;

  // Fullness is judged on the pre-edge state, so a write to a full queue
  // is dropped even when a pop happens on the same edge.
  always_comb begin
    wr_ok_c  = wr_i && !full_q;
    pop_ok_c = pop_i && !empty_q;
    wr_ptr_d = wr_ok_c  ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(wr_ok_c) - CNT_W'(pop_ok_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CNT_W'(DEPTH));
      empty_q  <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok_c) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = count_q;

endmodule

// File: rtl/node_port.sv
// Node network adapter: queues packets from the node, serialises them into
// four MSB-first flits outbound and reassembles inbound flits into packets.
// NODE_PORT_BYPASS_EN lets a packet skip an empty queue when TX is idle.
module node_port
  import node_port_pkg::*;
#(
  parameter int          NODEID = 0,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  pkt_t              pkt_in,
  input  logic              pkt_in_avail,
  output logic              cQ_full,
  output pkt_t              pkt_out,
  output logic              pkt_out_avail,
  input  logic              free_outbound,
  output logic              put_outbound,
  output logic [FLIT_W-1:0] payload_outbound,
  output logic              free_inbound,
  input  logic              put_inbound,
  input  logic [FLIT_W-1:0] payload_inbound
);

  localparam logic [FLIT_CNT_W-1:0] LAST_FLIT = FLIT_CNT_W'(FLITS_PER_PKT - 1);
  localparam int unsigned           TAIL_W    = PKT_W - FLIT_W;

  pkt_t                fifo_head;
  logic                fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                fifo_wr_c, pop_c, bypass_c, load_c, start_ok_c;
  pkt_t                load_pkt_c;

  tx_state_e             tx_state_q, tx_state_d;
  logic [FLIT_CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [PKT_W-1:0]      shift_q, shift_d;
  logic                  put_q, put_d;
  logic [FLIT_W-1:0]     payload_q, payload_d;

  rx_state_e             rx_state_q, rx_state_d;
  logic [FLIT_CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [PKT_W-1:0]      acc_q, acc_d;
  pkt_t                  pkt_out_q, pkt_out_d;
  logic                  avail_q, avail_d;
  logic                  free_in_q, free_in_d;
  logic                  rx_abort_c;

`ifdef NODE_PORT_BYPASS_EN
  assign bypass_c = pkt_in_avail && fifo_empty && (tx_state_q == TX_IDLE) && free_outbound;
`else
  assign bypass_c = 1'b0;
`endif

  assign fifo_wr_c = pkt_in_avail && !bypass_c;

  node_fifo #(
    .DEPTH (DEPTH),
    .T     (pkt_t)
  ) u_fifo (
    .clk       (clock),
    .rst_n     (reset_n),
    .wr_i      (fifo_wr_c),
    .wr_data_i (pkt_in),
    .pop_i     (pop_c),
    .head_o    (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  // TX next state: a new packet may start from idle or straight after the
  // last flit of the previous one, which keeps back-to-back packets gapless.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    shift_d    = shift_q;
    put_d      = 1'b0;
    payload_d  = '0;
    pop_c      = 1'b0;
    load_c     = 1'b0;
    load_pkt_c = fifo_head;
    start_ok_c = !fifo_empty && free_outbound;

    case (tx_state_q)
      TX_IDLE: begin
        if (bypass_c) begin
          load_c     = 1'b1;
          load_pkt_c = pkt_in;
        end else if (start_ok_c) begin
          load_c = 1'b1;
          pop_c  = 1'b1;
        end
      end
      TX_SEND: begin
        if (tx_cnt_q != LAST_FLIT) begin
          tx_cnt_d  = tx_cnt_q + FLIT_CNT_W'(1);
          shift_d   = {shift_q[TAIL_W-1:0], FLIT_W'(0)};
          put_d     = 1'b1;
          payload_d = shift_q[TAIL_W-1 -: FLIT_W];
        end else if (start_ok_c) begin
          load_c = 1'b1;
          pop_c  = 1'b1;
        end else begin
          tx_state_d = TX_IDLE;
          tx_cnt_d   = '0;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase

    if (load_c) begin
      tx_state_d = TX_SEND;
      tx_cnt_d   = '0;
      shift_d    = load_pkt_c;
      put_d      = 1'b1;
      payload_d  = head_flit(load_pkt_c);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      shift_q    <= '0;
      put_q      <= 1'b0;
      payload_q  <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      shift_q    <= shift_d;
      put_q      <= put_d;
      payload_q  <= payload_d;
    end
  end

  // RX next state: a missing flit mid-packet discards the partial packet.
  // free_inbound stays low through the delivery strobe cycle.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    acc_d      = acc_q;
    pkt_out_d  = pkt_out_q;
    avail_d    = 1'b0;
    rx_abort_c = 1'b0;

    case (rx_state_q)
      RX_IDLE: begin
        if (put_inbound) begin
          acc_d      = {acc_q[TAIL_W-1:0], payload_inbound};
          rx_cnt_d   = FLIT_CNT_W'(1);
          rx_state_d = RX_RECV;
        end
      end
      RX_RECV: begin
        if (put_inbound) begin
          acc_d = {acc_q[TAIL_W-1:0], payload_inbound};
          if (rx_cnt_q == LAST_FLIT) begin
            rx_state_d = RX_DONE;
            rx_cnt_d   = '0;
          end else begin
            rx_cnt_d = rx_cnt_q + FLIT_CNT_W'(1);
          end
        end else begin
          rx_abort_c = 1'b1;
          rx_state_d = RX_IDLE;
          rx_cnt_d   = '0;
        end
      end
      RX_DONE: begin
        pkt_out_d  = acc_q;
        avail_d    = 1'b1;
        rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase

    free_in_d = (rx_state_d == RX_IDLE) && (rx_state_q != RX_DONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      acc_q      <= '0;
      pkt_out_q  <= '0;
      avail_q    <= 1'b0;
      free_in_q  <= 1'b1;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      acc_q      <= acc_d;
      pkt_out_q  <= pkt_out_d;
      avail_q    <= avail_d;
      free_in_q  <= free_in_d;
    end
  end

  assign cQ_full          = fifo_full;
  assign put_outbound     = put_q;
  assign payload_outbound = payload_q;
  assign pkt_out          = pkt_out_q;
  assign pkt_out_avail    = avail_q;
  assign free_inbound     = free_in_q;

`ifndef SYNTHESIS
  // Simulation-only traces for dropped writes, aborted receives and foreign sources.
  always_ff @(posedge clock) begin
    if (reset_n) begin
      if (pkt_in_avail && fifo_full) begin
        $display("node_port %0d: warning: queue full (%0d), packet %08h dropped",
                 NODEID, fifo_count, pkt_in);
      end
      if (rx_abort_c) begin
        $display("node_port %0d: warning: inbound packet truncated, discarded", NODEID);
      end
      if (load_c && (load_pkt_c.src != 4'(NODEID))) begin
        $display("node_port %0d: warning: outbound packet %08h has src %0d",
                 NODEID, load_pkt_c, load_pkt_c.src);
      end
    end
  end
`endif

endmodule

// File: tb/tb_node_port.sv
// Directed bench for node_port: TX serialisation, queue fill/drop, RX
// reassembly, truncated receive, mid-packet reset and concurrent traffic.
module tb_node_port;
  import node_port_pkg::*;

`ifdef NODE_PORT_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  pkt_t       pkt_in;
  logic       pkt_in_avail;
  logic       cQ_full;
  pkt_t       pkt_out;
  logic       pkt_out_avail;
  logic       free_outbound;
  logic       put_outbound;
  logic [7:0] payload_outbound;
  logic       free_inbound;
  logic       put_inbound;
  logic [7:0] payload_inbound;

  int n_tests = 0;
  int n_fail  = 0;

  int          n_put, first_put, last_put, avail_n, avail_idx, free_low;
  logic [31:0] tx_acc, rx_word;
  logic [31:0] tx_words[$];
  logic        full_hist[5];

  always #5 clk = ~clk;

  node_port #(.NODEID(1), .DEPTH(4)) dut (
    .clock            (clk),
    .reset_n          (reset_n),
    .pkt_in           (pkt_in),
    .pkt_in_avail     (pkt_in_avail),
    .cQ_full          (cQ_full),
    .pkt_out          (pkt_out),
    .pkt_out_avail    (pkt_out_avail),
    .free_outbound    (free_outbound),
    .put_outbound     (put_outbound),
    .payload_outbound (payload_outbound),
    .free_inbound     (free_inbound),
    .put_inbound      (put_inbound),
    .payload_inbound  (payload_inbound)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs n cycles: optional TX write at cycle 0, rx_flits inbound flits of
  // rx_pkt from cycle 0, and records what the DUT emits after each edge.
  task automatic run(input int n, input logic tx_wr, input logic [31:0] tx_pkt,
                     input int rx_flits, input logic [31:0] rx_pkt);
    logic [31:0] w;
    n_put = 0; first_put = -1; last_put = -1;
    avail_n = 0; avail_idx = -1; free_low = 0;
    tx_acc = '0; rx_word = '0;
    tx_words.delete();
    for (int k = 0; k < n; k++) begin
      pkt_in       = tx_pkt;
      pkt_in_avail = tx_wr && (k == 0);
      w            = rx_pkt << (8 * k);
      put_inbound     = (k < rx_flits);
      payload_inbound = (k < rx_flits) ? w[31:24] : 8'h00;
      tick();
      if (put_outbound) begin
        if (first_put < 0) first_put = k;
        last_put = k;
        n_put++;
        tx_acc = {tx_acc[23:0], payload_outbound};
        if (n_put % 4 == 0) tx_words.push_back(tx_acc);
      end
      if (pkt_out_avail) begin
        avail_n++;
        avail_idx = k;
        rx_word   = pkt_out;
      end
      if (!free_inbound) free_low++;
    end
    pkt_in_avail    = 1'b0;
    put_inbound     = 1'b0;
    payload_inbound = 8'h00;
  endtask

  initial begin
    reset_n         = 1'b0;
    pkt_in          = '0;
    pkt_in_avail    = 1'b0;
    free_outbound   = 1'b0;
    put_inbound     = 1'b0;
    payload_inbound = 8'h00;
    #12;
    check_eq("rst_cq_full", 32'(cQ_full), 32'd0);
    check_eq("rst_put", 32'(put_outbound), 32'd0);
    check_eq("rst_payload", 32'(payload_outbound), 32'd0);
    check_eq("rst_free_in", 32'(free_inbound), 32'd1);
    check_eq("rst_avail", 32'(pkt_out_avail), 32'd0);
    check_eq("rst_pkt_out", pkt_out, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // Single packet, free link.
    free_outbound = 1'b1;
    run(8, 1'b1, 32'h1234_5678, 0, 32'h0);
    check_eq("tx1_latency", 32'(first_put), 32'(LAT - 1));
    check_eq("tx1_nflits", 32'(n_put), 32'd4);
    check_eq("tx1_contig", 32'(last_put - first_put), 32'd3);
    check_eq("tx1_word", (tx_words.size() > 0) ? tx_words[0] : 32'hDEAD_DEAD, 32'h1234_5678);
    check_eq("tx1_idle_after", 32'(put_outbound), 32'd0);

    // Fill the queue with the link blocked; the fifth write is dropped.
    free_outbound = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pkt_in       = 32'h1A00_0001 + 32'(i);
      pkt_in_avail = 1'b1;
      tick();
      full_hist[i] = cQ_full;
    end
    pkt_in_avail = 1'b0;
    check_eq("fill_full_after3", 32'(full_hist[2]), 32'd0);
    check_eq("fill_full_after4", 32'(full_hist[3]), 32'd1);
    check_eq("fill_full_after5", 32'(full_hist[4]), 32'd1);
    check_eq("fill_no_put", 32'(put_outbound), 32'd0);
    free_outbound = 1'b1;
    run(24, 1'b0, 32'h0, 0, 32'h0);
    check_eq("drain_first", 32'(first_put), 32'd0);
    check_eq("drain_nflits", 32'(n_put), 32'd16);
    check_eq("drain_contig", 32'(last_put - first_put), 32'd15);
    check_eq("drain_npkts", 32'(tx_words.size()), 32'd4);
    for (int i = 0; i < tx_words.size(); i++)
      check_eq("drain_word", tx_words[i], 32'h1A00_0001 + 32'(i));
    check_eq("drain_full", 32'(cQ_full), 32'd0);

    // Inbound reassembly.
    run(8, 1'b0, 32'h0, 4, 32'hA1B2_C3D4);
    check_eq("rx_nstrobe", 32'(avail_n), 32'd1);
    check_eq("rx_strobe_idx", 32'(avail_idx), 32'd4);
    check_eq("rx_word", rx_word, 32'hA1B2_C3D4);
    check_eq("rx_free_low", 32'(free_low), 32'd5);

    // Truncated after two flits, then a good packet.
    run(6, 1'b0, 32'h0, 2, 32'h9988_7766);
    check_eq("trunc_nstrobe", 32'(avail_n), 32'd0);
    check_eq("trunc_free_low", 32'(free_low), 32'd2);
    check_eq("trunc_free_now", 32'(free_inbound), 32'd1);
    run(8, 1'b0, 32'h0, 4, 32'h5566_7788);
    check_eq("after_trunc_nstrobe", 32'(avail_n), 32'd1);
    check_eq("after_trunc_word", rx_word, 32'h5566_7788);

    // Reset in the middle of a TX and an RX packet.
    pkt_in          = 32'h1CCC_DDDD;
    pkt_in_avail    = 1'b1;
    put_inbound     = 1'b1;
    payload_inbound = 8'h11;
    tick();
    pkt_in_avail    = 1'b0;
    payload_inbound = 8'h22;
    tick();
    payload_inbound = 8'h33;
    tick();
    check_eq("mid_put_active", 32'(put_outbound), 32'd1);
    check_eq("mid_free_low", 32'(free_inbound), 32'd0);
    #3;
    reset_n = 1'b0;
    #1;
    check_eq("arst_put", 32'(put_outbound), 32'd0);
    check_eq("arst_payload", 32'(payload_outbound), 32'd0);
    check_eq("arst_free_in", 32'(free_inbound), 32'd1);
    check_eq("arst_avail", 32'(pkt_out_avail), 32'd0);
    check_eq("arst_pkt_out", pkt_out, 32'd0);
    check_eq("arst_cq_full", 32'(cQ_full), 32'd0);
    put_inbound     = 1'b0;
    payload_inbound = 8'h00;
    tick();
    reset_n = 1'b1;
    run(8, 1'b0, 32'h0, 0, 32'h0);
    check_eq("post_rst_nflits", 32'(n_put), 32'd0);
    check_eq("post_rst_nstrobe", 32'(avail_n), 32'd0);
    check_eq("post_rst_free_low", 32'(free_low), 32'd0);

    // Concurrent TX and RX of different packets.
    run(10, 1'b1, 32'h1BAD_BEEF, 4, 32'hA1B2_C3D4);
    check_eq("dual_tx_latency", 32'(first_put), 32'(LAT - 1));
    check_eq("dual_tx_nflits", 32'(n_put), 32'd4);
    check_eq("dual_tx_word", (tx_words.size() > 0) ? tx_words[0] : 32'hDEAD_DEAD, 32'h1BAD_BEEF);
    check_eq("dual_rx_strobe_idx", 32'(avail_idx), 32'd4);
    check_eq("dual_rx_word", rx_word, 32'hA1B2_C3D4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
